// File: rtl/sched_pkg.sv
// sched_pkg: shared defaults, FSM states and the occupancy-to-priority
// mapping used by the pSLIP request stage.
package sched_pkg;

  localparam int N_DEF       = 4;
  localparam int P_DEF       = 16;
  localparam int DEPTH_DEF   = 64;
  localparam int SHIFT_DEF   = 2;
  localparam int TIMEOUT_DEF = 64;
  localparam int PW          = $clog2(P_DEF);

  typedef enum logic [2:0] {
    IDLE,
    SNAP,
    WAIT_BUSY,
    WAIT_DONE,
    COMMIT
  } state_t;

  // Zero means no request; otherwise one level per 2**shift cells,
  // saturating at the top level.
  function automatic logic [PW-1:0] pri_encode(
    input int occ,
    input int shift = SHIFT_DEF,
    input int pmax  = P_DEF
  );
    int lvl;
    if (occ <= 0) return '0;
    lvl = ((occ - 1) >> shift) + 1;
    if (lvl > pmax - 1) lvl = pmax - 1;
    return PW'(lvl);
  endfunction

endpackage

// File: rtl/voq_occ_counter.sv
// voq_occ_counter: one saturating VOQ occupancy counter.
// A same-cycle arrival and retire cancel, even when the queue is full.
module voq_occ_counter
  import sched_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W     = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] occ,
  output logic         full
);

  assign full = (occ == W'(DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ <= '0;
    end else if (inc && !dec && !full) begin
      occ <= occ + W'(1);
    end else if (dec && !inc && occ != '0) begin
      occ <= occ - W'(1);
    end
  end

endmodule

// File: rtl/voq_pri_req_gen.sv
// voq_pri_req_gen: VOQ occupancy tracking, per-slot priority snapshot
// and start/ready sequencing for the pSLIP scheduler.
module voq_pri_req_gen
  import sched_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int P       = P_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int SHIFT   = SHIFT_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N-1:0]                 arr_valid,
  input  logic [N-1:0][$clog2(N)-1:0]  arr_dst,
  input  logic                         slot_start,
  input  logic [N-1:0][N-1:0]          decision,
  input  logic                         decision_ready,
  output logic [$clog2(P)-1:0]         pri_req_out [0:N-1][0:N-1],
  output logic                         sched_start,
  output logic [N-1:0][N-1:0]          xbar_cfg,
  output logic                         xbar_valid,
  output logic [N-1:0]                 drop,
  output logic                         busy,
  output logic                         proto_err
);

  localparam int DW  = $clog2(N);
  localparam int PRW = $clog2(P);
  localparam int OW  = $clog2(DEPTH + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);

  state_t              state, state_nx;
  logic [TW-1:0]       tcnt;
  logic [OW-1:0]       occ [N][N];
  logic [N-1:0][N-1:0] inc, dec, full;
  logic [PRW-1:0]      pri_nx [N][N];
  logic [N-1:0]        col;
  logic                in_wait, timeout, snap, accept;
  logic                err, commit_err;

  assign in_wait = (state == WAIT_BUSY) || (state == WAIT_DONE);
  assign timeout = in_wait && (tcnt == TW'(TIMEOUT - 1));
  assign snap    = (state == IDLE) && slot_start;
  assign accept  = (state == WAIT_DONE) && decision_ready && !timeout;
  assign busy    = (state != IDLE);

  // Retire uses the decision captured on the ready edge, not the live bus.
  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        inc[i][j] = arr_valid[i] && (arr_dst[i] == DW'(j));
        dec[i][j] = (state == COMMIT) && xbar_cfg[i][j]
                    && (occ[i][j] != '0);
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      voq_occ_counter #(
        .DEPTH (DEPTH),
        .W     (OW)
      ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (inc[gi][gj]),
        .dec   (dec[gi][gj]),
        .occ   (occ[gi][gj]),
        .full  (full[gi][gj])
      );
    end
  end

  // Snapshot includes arrivals landing on the same edge as slot_start.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        pri_nx[i][j] = PRW'(pri_encode(
          int'(occ[i][j]) + int'(inc[i][j] && !full[i][j]),
          SHIFT, P));
      end
    end
  end

  always_comb begin
    err = 1'b0;
    col = '0;
    for (int i = 0; i < N; i++) begin
      if ($countones(xbar_cfg[i]) > 1) err = 1'b1;
    end
    for (int j = 0; j < N; j++) begin
      for (int i = 0; i < N; i++) col[i] = xbar_cfg[i][j];
      if ($countones(col) > 1) err = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (xbar_cfg[i][j] && occ[i][j] == '0) err = 1'b1;
      end
    end
    commit_err = (state == COMMIT) && err;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (slot_start) state_nx = SNAP;
      SNAP:      state_nx = WAIT_BUSY;
      WAIT_BUSY: begin
        if (timeout)             state_nx = IDLE;
        else if (!decision_ready) state_nx = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (timeout)             state_nx = IDLE;
        else if (decision_ready) state_nx = COMMIT;
      end
      COMMIT:    state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      tcnt        <= '0;
      sched_start <= 1'b0;
      xbar_valid  <= 1'b0;
      xbar_cfg    <= '0;
      drop        <= '0;
      proto_err   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) pri_req_out[i][j] <= '0;
      end
    end else begin
      state       <= state_nx;
      tcnt        <= in_wait ? tcnt + TW'(1) : '0;
      sched_start <= snap;
      xbar_valid  <= accept;
      if (accept) xbar_cfg <= decision;
      proto_err   <= proto_err | timeout | commit_err;
      for (int i = 0; i < N; i++) begin
        drop[i] <= arr_valid[i] && full[i][arr_dst[i]]
                   && !dec[i][arr_dst[i]];
      end
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (snap) pri_req_out[i][j] <= pri_nx[i][j];
          else if (state == COMMIT || timeout) pri_req_out[i][j] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_voq_pri_req_gen.sv
// tb_voq_pri_req_gen: scenario tasks with randomized traffic checked
// against an occupancy-array model of the request stage.
module tb_voq_pri_req_gen;

  localparam int N     = 4;
  localparam int DEPTH = 64;

  logic                clk = 1'b0;
  logic                reset;
  logic [N-1:0]        arr_valid;
  logic [N-1:0][1:0]   arr_dst;
  logic                slot_start;
  logic [N-1:0][N-1:0] decision;
  logic                decision_ready;
  logic [3:0]          pri_req_out [0:N-1][0:N-1];
  logic                sched_start;
  logic [N-1:0][N-1:0] xbar_cfg;
  logic                xbar_valid;
  logic [N-1:0]        drop;
  logic                busy;
  logic                proto_err;

  int         total = 0;
  int         bad   = 0;
  int         occ_m  [N][N];
  int         snap_m [N][N];
  logic [3:0] snap_got [N][N];
  bit         perr_m;

  voq_pri_req_gen dut (
    .clk            (clk),
    .reset          (reset),
    .arr_valid      (arr_valid),
    .arr_dst        (arr_dst),
    .slot_start     (slot_start),
    .decision       (decision),
    .decision_ready (decision_ready),
    .pri_req_out    (pri_req_out),
    .sched_start    (sched_start),
    .xbar_cfg       (xbar_cfg),
    .xbar_valid     (xbar_valid),
    .drop           (drop),
    .busy           (busy),
    .proto_err      (proto_err)
  );

  always #5 clk = ~clk;

  function automatic int pri_of(input int o);
    int l;
    if (o == 0) return 0;
    l = (o - 1) / 4 + 1;
    return (l > 15) ? 15 : l;
  endfunction

  task automatic model_clear();
    perr_m = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        occ_m[i][j]  = 0;
        snap_m[i][j] = 0;
      end
  endtask

  // One clock: drive arrivals, update the occupancy model with the
  // arrivals and any retire mask cm, report the expected drop vector.
  task automatic tick(input logic [N-1:0] av, input logic [N-1:0][1:0] ad,
                      input logic [N-1:0][N-1:0] cm,
                      output logic [N-1:0] ed);
    int  rc, cc;
    bit  a, d;
    arr_valid = av;
    arr_dst   = ad;
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      rc = 0;
      cc = 0;
      for (int j = 0; j < N; j++) begin
        rc += int'(cm[i][j]);
        cc += int'(cm[j][i]);
        if (cm[i][j] && occ_m[i][j] == 0) perr_m = 1'b1;
      end
      if (rc > 1 || cc > 1) perr_m = 1'b1;
    end
    ed = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        a = av[i] && (int'(ad[i]) == j);
        d = cm[i][j] && occ_m[i][j] > 0;
        if (a && d) ;
        else if (a && occ_m[i][j] == DEPTH) ed[i] = 1'b1;
        else if (a) occ_m[i][j]++;
        else if (d) occ_m[i][j]--;
      end
    #1;
    arr_valid  = '0;
    slot_start = 1'b0;
  endtask

  task automatic rnd_arr(input bit en, output logic [N-1:0] av,
                         output logic [N-1:0][1:0] ad);
    av = '0;
    ad = '0;
    if (en)
      for (int i = 0; i < N; i++) begin
        av[i] = ($urandom_range(0, 2) == 0);
        ad[i] = 2'($urandom_range(0, 3));
      end
  endtask

  task automatic pri_diff(output bit diff, output int fi, output int fj,
                          output int g, output int e);
    diff = 1'b0; fi = 0; fj = 0; g = 0; e = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (!diff && pri_req_out[i][j] !== 4'(snap_m[i][j])) begin
          diff = 1'b1; fi = i; fj = j;
          g = int'(pri_req_out[i][j]); e = snap_m[i][j];
        end
  endtask

  task automatic do_round(input logic [N-1:0][N-1:0] dec, input int low,
                          input bit rnd, input logic [N-1:0] cav,
                          input logic [N-1:0][1:0] cad);
    logic [N-1:0]      av, ed;
    logic [N-1:0][1:0] ad;
    bit                diff;
    int                fi, fj, g, e;
    rnd_arr(rnd, av, ad);
    slot_start = 1'b1;
    tick(av, ad, '0, ed);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        snap_m[i][j]   = pri_of(occ_m[i][j]);
        snap_got[i][j] = pri_req_out[i][j];
      end
    total++;
    if (sched_start !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL snap_start: sched_start=%b busy=%b want 1 1",
               sched_start, busy);
    end
    pri_diff(diff, fi, fj, g, e);
    total++;
    if (diff) begin
      bad++;
      $display("FAIL snap_pri: [%0d][%0d] got %0d want %0d", fi, fj, g, e);
    end
    total++;
    if (drop !== ed) begin
      bad++;
      $display("FAIL snap_drop: got %b want %b", drop, ed);
    end
    decision_ready = 1'b0;
    for (int k = 0; k < low; k++) begin
      rnd_arr(rnd, av, ad);
      slot_start = rnd && ($urandom_range(0, 3) == 0);
      tick(av, ad, '0, ed);
      pri_diff(diff, fi, fj, g, e);
      total++;
      if (sched_start !== 1'b0 || xbar_valid !== 1'b0 || diff
          || drop !== ed) begin
        bad++;
        $display("FAIL wait_hold: k=%0d ss=%b xv=%b pri[%0d][%0d]=%0d/%0d drop=%b want 0 0 %0d %b",
                 k, sched_start, xbar_valid, fi, fj, g, e, drop, e, ed);
      end
    end
    decision       = dec;
    decision_ready = 1'b1;
    rnd_arr(rnd, av, ad);
    tick(av, ad, '0, ed);
    total++;
    if (xbar_valid !== 1'b1 || xbar_cfg !== dec) begin
      bad++;
      $display("FAIL commit_cfg: xv=%b cfg=%h want 1 %h",
               xbar_valid, xbar_cfg, dec);
    end
    decision = 16'($urandom);
    if (rnd) rnd_arr(1'b1, av, ad);
    else begin
      av = cav;
      ad = cad;
    end
    tick(av, ad, dec, ed);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) snap_m[i][j] = 0;
    pri_diff(diff, fi, fj, g, e);
    total++;
    if (xbar_valid !== 1'b0 || busy !== 1'b0 || xbar_cfg !== dec || diff) begin
      bad++;
      $display("FAIL commit_done: xv=%b busy=%b cfg=%h pri[%0d][%0d]=%0d want 0 0 %h 0",
               xbar_valid, busy, xbar_cfg, fi, fj, g, dec);
    end
    total++;
    if (drop !== ed || proto_err !== perr_m) begin
      bad++;
      $display("FAIL commit_flags: drop=%b perr=%b want %b %b",
               drop, proto_err, ed, perr_m);
    end
    decision = '0;
  endtask

  task automatic test_reset();
    bit diff;
    int fi, fj, g, e;
    reset = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (sched_start !== 1'b0 || xbar_valid !== 1'b0 || xbar_cfg !== '0
        || drop !== '0 || busy !== 1'b0 || proto_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_outs: ss=%b xv=%b cfg=%h drop=%b busy=%b perr=%b want all 0",
               sched_start, xbar_valid, xbar_cfg, drop, busy, proto_err);
    end
    pri_diff(diff, fi, fj, g, e);
    total++;
    if (diff) begin
      bad++;
      $display("FAIL reset_pri: [%0d][%0d] got %0d want 0", fi, fj, g);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_snapshot_commit();
    logic [N-1:0]        ed;
    logic [N-1:0][1:0]   ad;
    logic [N-1:0][N-1:0] d;
    ad    = '0;
    ad[0] = 2'd2;
    for (int k = 0; k < 5; k++) begin
      tick(4'b0001, ad, '0, ed);
      total++;
      if (drop !== ed) begin
        bad++;
        $display("FAIL arr_drop: got %b want %b", drop, ed);
      end
    end
    d       = '0;
    d[0][2] = 1'b1;
    do_round(d, 32, 1'b0, '0, '0);
    total++;
    if (snap_got[0][2] !== 4'd2) begin
      bad++;
      $display("FAIL pri_02: got %0d want 2", snap_got[0][2]);
    end
    do_round('0, 2, 1'b0, '0, '0);
    total++;
    if (snap_got[0][2] !== 4'd1) begin
      bad++;
      $display("FAIL pri_02_after: got %0d want 1", snap_got[0][2]);
    end
  endtask

  task automatic test_full_drop();
    logic [N-1:0]      ed;
    logic [N-1:0][1:0] ad;
    ad    = '0;
    ad[1] = 2'd3;
    for (int k = 0; k < 80 && occ_m[1][3] < DEPTH; k++) begin
      tick(4'b0010, ad, '0, ed);
      total++;
      if (drop !== ed) begin
        bad++;
        $display("FAIL fill_drop: k=%0d got %b want %b", k, drop, ed);
      end
    end
    tick(4'b0010, ad, '0, ed);
    total++;
    if (drop !== 4'b0010 || ed !== 4'b0010) begin
      bad++;
      $display("FAIL full_drop: got %b want 0010", drop);
    end
    tick('0, '0, '0, ed);
    total++;
    if (drop !== 4'b0000) begin
      bad++;
      $display("FAIL drop_pulse: got %b want 0000", drop);
    end
    do_round('0, 3, 1'b0, '0, '0);
    total++;
    if (snap_got[1][3] !== 4'd15) begin
      bad++;
      $display("FAIL pri_sat: got %0d want 15", snap_got[1][3]);
    end
  endtask

  task automatic test_same_cycle();
    logic [N-1:0]        ed;
    logic [N-1:0][1:0]   ad;
    logic [N-1:0][N-1:0] d;
    ad      = '0;
    ad[1]   = 2'd3;
    d       = '0;
    d[1][3] = 1'b1;
    do_round(d, 2, 1'b0, 4'b0010, ad);
    total++;
    if (drop !== 4'b0000 || occ_m[1][3] != DEPTH) begin
      bad++;
      $display("FAIL same_cycle_drop: got %b want 0000", drop);
    end
    tick(4'b0010, ad, '0, ed);
    total++;
    if (drop !== 4'b0010) begin
      bad++;
      $display("FAIL still_full: got %b want 0010", drop);
    end
  endtask

  task automatic test_timeout();
    logic [N-1:0] ed;
    bit           saw, diff;
    int           fi, fj, g, e;
    saw            = 1'b0;
    decision_ready = 1'b1;
    slot_start     = 1'b1;
    tick('0, '0, '0, ed);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) snap_m[i][j] = pri_of(occ_m[i][j]);
    for (int k = 0; k < 64; k++) begin
      tick('0, '0, '0, ed);
      if (xbar_valid === 1'b1) saw = 1'b1;
    end
    total++;
    if (proto_err !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL timeout_early: perr=%b busy=%b want 0 1", proto_err, busy);
    end
    perr_m = 1'b1;
    tick('0, '0, '0, ed);
    if (xbar_valid === 1'b1) saw = 1'b1;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) snap_m[i][j] = 0;
    total++;
    if (proto_err !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL timeout_fire: perr=%b busy=%b want 1 0", proto_err, busy);
    end
    pri_diff(diff, fi, fj, g, e);
    tick('0, '0, '0, ed);
    if (xbar_valid === 1'b1) saw = 1'b1;
    total++;
    if (diff || saw || busy !== 1'b0) begin
      bad++;
      $display("FAIL timeout_idle: pri=%0d xv_seen=%b busy=%b want 0 0 0",
               g, saw, busy);
    end
  endtask

  task automatic test_zero_decision();
    logic [N-1:0][N-1:0] d;
    reset = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    reset   = 1'b0;
    d       = '0;
    d[2][0] = 1'b1;
    do_round(d, 2, 1'b0, '0, '0);
    total++;
    if (proto_err !== 1'b1) begin
      bad++;
      $display("FAIL zero_occ_err: got %b want 1", proto_err);
    end
    do_round('0, 2, 1'b0, '0, '0);
    total++;
    if (snap_got[2][0] !== 4'd0) begin
      bad++;
      $display("FAIL zero_occ_pri: got %0d want 0", snap_got[2][0]);
    end
  endtask

  task automatic test_reset_mid_round();
    logic [N-1:0]      ed;
    logic [N-1:0][1:0] ad;
    bit                saw, diff;
    int                fi, fj, g, e;
    ad    = '0;
    ad[3] = 2'd1;
    tick(4'b1000, ad, '0, ed);
    slot_start = 1'b1;
    tick('0, '0, '0, ed);
    decision_ready = 1'b0;
    tick('0, '0, '0, ed);
    tick('0, '0, '0, ed);
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    total++;
    if (sched_start !== 1'b0 || xbar_valid !== 1'b0 || xbar_cfg !== '0
        || drop !== '0 || busy !== 1'b0 || proto_err !== 1'b0) begin
      bad++;
      $display("FAIL midreset_outs: ss=%b xv=%b cfg=%h drop=%b busy=%b perr=%b want all 0",
               sched_start, xbar_valid, xbar_cfg, drop, busy, proto_err);
    end
    pri_diff(diff, fi, fj, g, e);
    total++;
    if (diff) begin
      bad++;
      $display("FAIL midreset_pri: [%0d][%0d] got %0d want 0", fi, fj, g);
    end
    @(negedge clk);
    reset          = 1'b0;
    decision_ready = 1'b1;
    decision       = 16'hffff;
    saw            = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick('0, '0, '0, ed);
      if (xbar_valid !== 1'b0 || busy !== 1'b0) saw = 1'b1;
    end
    decision = '0;
    total++;
    if (saw) begin
      bad++;
      $display("FAIL midreset_idle: xv=%b busy=%b want 0 0", xbar_valid, busy);
    end
    do_round('0, 2, 1'b0, '0, '0);
    total++;
    if (snap_got[3][1] !== 4'd0) begin
      bad++;
      $display("FAIL midreset_occ: got %0d want 0", snap_got[3][1]);
    end
  endtask

  task automatic test_random_rounds();
    logic [N-1:0][N-1:0] d;
    logic [N-1:0]        used;
    int                  j;
    for (int r = 0; r < 16; r++) begin
      d    = '0;
      used = '0;
      if ($urandom_range(0, 3) == 0) begin
        d = 16'($urandom);
      end else begin
        for (int i = 0; i < N; i++)
          if ($urandom_range(0, 1) == 1) begin
            j = $urandom_range(0, 3);
            if (!used[j]) begin
              d[i][j] = 1'b1;
              used[j] = 1'b1;
            end
          end
      end
      do_round(d, $urandom_range(2, 40), 1'b1, '0, '0);
    end
  endtask

  initial begin
    reset          = 1'b1;
    arr_valid      = '0;
    arr_dst        = '0;
    slot_start     = 1'b0;
    decision       = '0;
    decision_ready = 1'b1;
    model_clear();
    test_reset();
    test_snapshot_commit();
    test_full_drop();
    test_same_cycle();
    test_timeout();
    test_zero_decision();
    test_reset_mid_round();
    test_random_rounds();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
